// File: rtl/seg7_pkg.sv
// seg7_pkg: shared anode codes, blank patterns and state encoding for the seven-segment digit driver
package seg7_pkg;
  localparam logic [3:0] DIG3 = 4'b0111;
  localparam logic [3:0] DIG2 = 4'b1011;
  localparam logic [3:0] DIG1 = 4'b1101;
  localparam logic [3:0] DIG0 = 4'b1110;
  localparam logic [3:0] BLANK_AN = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to active-low segment pattern, seg[0]=a .. seg[6]=g
module seg7_hex_decode (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // one pattern per hex value
  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

// File: rtl/seg7_digit_driver.sv
// seg7_digit_driver: per-digit cathode driver with frame-aligned double-buffered display value
module seg7_digit_driver
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_in,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic        ready,
  output logic [3:0]  an_out,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        an_err
);
  state_t      state_q, state_d;
  logic [15:0] disp_q, disp_d, shadow_q, shadow_d, eff;
  logic [3:0]  disp_dp_q, disp_dp_d, shadow_dp_q, shadow_dp_d, eff_dp, an_out_q, an_out_d, nib;
  logic [6:0]  seg_q, seg_d, hex_seg;
  logic        dp_q, dp_d, an_err_q, an_err_d;
  logic        frame_start, legal, accept, direct, commit, z3, z2, z1, blank;
  logic [1:0]  k;

  seg7_hex_decode u_dec (.nib(nib), .seg(hex_seg));

  // handshake, frame-start commit with same-cycle bypass, digit select and blanking
  always_comb begin
    frame_start = an_in == DIG3;
    legal = an_in inside {DIG3, DIG2, DIG1, DIG0};
    accept = load && state_q == IDLE;
    direct = accept && frame_start;
    commit = frame_start && (direct || state_q == PEND);
    eff = direct ? data_in : commit ? shadow_q : disp_q;
    eff_dp = direct ? dp_in : commit ? shadow_dp_q : disp_dp_q;
    k = an_in == DIG3 ? 2'd3 : an_in == DIG2 ? 2'd2 : an_in == DIG1 ? 2'd1 : 2'd0;
    nib = eff[{k, 2'b00} +: 4];
    z3 = eff[15:12] == 4'h0;
    z2 = z3 && eff[11:8] == 4'h0;
    z1 = z2 && eff[7:4] == 4'h0;
    blank = lz_en && (k == 2'd3 ? z3 : k == 2'd2 ? z2 : k == 2'd1 ? z1 : 1'b0);
    state_d = (accept && !frame_start) ? PEND : frame_start ? IDLE : state_q;
    shadow_d = (accept && !frame_start) ? data_in : shadow_q;
    shadow_dp_d = (accept && !frame_start) ? dp_in : shadow_dp_q;
    disp_d = commit ? eff : disp_q;
    disp_dp_d = commit ? eff_dp : disp_dp_q;
    an_out_d = legal ? an_in : BLANK_AN;
    seg_d = (!legal || blank) ? SEG_BLANK : hex_seg;
    dp_d = legal ? ~eff_dp[k] : 1'b1;
    an_err_d = an_err_q || !legal;
  end

  // state, value buffers and registered pin drive
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      disp_q <= '0;
      disp_dp_q <= '0;
      shadow_q <= '0;
      shadow_dp_q <= '0;
      an_out_q <= BLANK_AN;
      seg_q <= SEG_BLANK;
      dp_q <= 1'b1;
      an_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q <= disp_d;
      disp_dp_q <= disp_dp_d;
      shadow_q <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      an_out_q <= an_out_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      an_err_q <= an_err_d;
    end
  end

  assign ready = state_q == IDLE;
  assign an_out = an_out_q;
  assign seg = seg_q;
  assign dp = dp_q;
  assign an_err = an_err_q;
endmodule

// File: tb/tb_seg7_digit_driver.sv
// tb_seg7_digit_driver: directed checks of digit decode, frame-aligned loads, blanking, illegal codes and reset
module tb_seg7_digit_driver;
  logic        clk = 1'b0, rst, load, lz_en, ready, dp, an_err;
  logic [3:0]  an_in, dp_in, an_out;
  logic [15:0] data_in;
  logic [6:0]  seg;
  int vec = 0, miss = 0;

  localparam logic [3:0] D3 = 4'b0111, D2 = 4'b1011, D1 = 4'b1101, D0 = 4'b1110;

  seg7_digit_driver dut (
    .clk(clk), .rst(rst), .an_in(an_in), .load(load), .data_in(data_in), .dp_in(dp_in),
    .lz_en(lz_en), .ready(ready), .an_out(an_out), .seg(seg), .dp(dp), .an_err(an_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic digit(input string tag, input logic [3:0] an, input logic [6:0] es, input logic ed);
    an_in = an;
    @(posedge clk);
    #1;
    chk({tag, "_an"}, 16'(an_out), 16'(an));
    chk({tag, "_seg"}, 16'(seg), 16'(es));
    chk({tag, "_dp"}, 16'(dp), 16'(ed));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 16'(an_out), 16'hF);
    chk({tag, "_seg"}, 16'(seg), 16'h7F);
    chk({tag, "_dp"}, 16'(dp), 16'h1);
    chk({tag, "_err"}, 16'(an_err), 16'h0);
    chk({tag, "_rdy"}, 16'(ready), 16'h1);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lz_en = 1'b0; an_in = D0; data_in = '0; dp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    digit("zero_d3", D3, 7'h40, 1'b1);
    digit("zero_d2", D2, 7'h40, 1'b1);
    digit("zero_d1", D1, 7'h40, 1'b1);
    digit("zero_d0", D0, 7'h40, 1'b1);
    chk("zero_rdy", 16'(ready), 16'h1);
    load = 1'b1; data_in = 16'h12AF; dp_in = 4'b0100;
    digit("pend_d2", D2, 7'h40, 1'b1);
    load = 1'b0;
    chk("pend_rdy0", 16'(ready), 16'h0);
    load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF;
    digit("pend_d1", D1, 7'h40, 1'b1);
    load = 1'b0;
    chk("pend_rdy1", 16'(ready), 16'h0);
    digit("pend_d0", D0, 7'h40, 1'b1);
    chk("pend_rdy2", 16'(ready), 16'h0);
    digit("new_d3", D3, 7'h79, 1'b1);
    chk("commit_rdy", 16'(ready), 16'h1);
    digit("new_d2", D2, 7'h24, 1'b0);
    digit("new_d1", D1, 7'h08, 1'b1);
    digit("new_d0", D0, 7'h0E, 1'b1);
    load = 1'b1; data_in = 16'h8888; dp_in = 4'b0000;
    digit("fs_d3", D3, 7'h00, 1'b1);
    load = 1'b0;
    chk("fs_rdy", 16'(ready), 16'h1);
    digit("fs_d2", D2, 7'h00, 1'b1);
    digit("fs_d1", D1, 7'h00, 1'b1);
    digit("fs_d0", D0, 7'h00, 1'b1);
    lz_en = 1'b1; load = 1'b1; data_in = 16'h0030; dp_in = 4'b1000;
    digit("lz_d3", D3, 7'h7F, 1'b0);
    load = 1'b0;
    digit("lz_d2", D2, 7'h7F, 1'b1);
    digit("lz_d1", D1, 7'h30, 1'b1);
    digit("lz_d0", D0, 7'h40, 1'b1);
    load = 1'b1; data_in = 16'h0000; dp_in = 4'b0000;
    digit("lz0_d3", D3, 7'h7F, 1'b1);
    load = 1'b0;
    digit("lz0_d2", D2, 7'h7F, 1'b1);
    digit("lz0_d1", D1, 7'h7F, 1'b1);
    digit("lz0_d0", D0, 7'h40, 1'b1);
    an_in = 4'b0011;
    @(posedge clk);
    #1;
    chk("ill_an", 16'(an_out), 16'hF);
    chk("ill_seg", 16'(seg), 16'h7F);
    chk("ill_dp", 16'(dp), 16'h1);
    chk("ill_err", 16'(an_err), 16'h1);
    lz_en = 1'b0;
    digit("after_ill_d3", D3, 7'h40, 1'b1);
    digit("after_ill_d2", D2, 7'h40, 1'b1);
    chk("err_sticky", 16'(an_err), 16'h1);
    load = 1'b1; data_in = 16'h5555; dp_in = 4'hF;
    digit("rp_d1", D1, 7'h40, 1'b1);
    load = 1'b0;
    chk("rp_rdy0", 16'(ready), 16'h0);
    rst = 1'b1; an_in = D0;
    @(posedge clk);
    #1;
    chk_reset("rst_pend");
    rst = 1'b0;
    digit("post_d3", D3, 7'h40, 1'b1);
    digit("post_d2", D2, 7'h40, 1'b1);
    digit("post_d1", D1, 7'h40, 1'b1);
    digit("post_d0", D0, 7'h40, 1'b1);
    chk("post_rdy", 16'(ready), 16'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
